// File: rtl/wdt_power_ctrl.sv
// Watchdog timer and power-down controller for the PIC16F core.
// Times the watchdog, executes the CLRWDT/SLEEP side effects, drives the
// status register TO/PD write ports, requests a core reset on a run-mode
// watchdog overflow and wakes the core from sleep.
module wdt_power_ctrl #(
    parameter int TICK_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wdt_en,
    input  logic       psa,
    input  logic [2:0] ps,
    input  logic       clrwdt,
    input  logic       sleep,
    input  logic       wake_evt,
    output logic       n_to_wr_en,
    output logic       n_to_in,
    output logic       n_pd_wr_en,
    output logic       n_pd_in,
    output logic       sleeping,
    output logic       wdt_reset,
    output logic       wake
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SLEEP   = 2'd1,
        ST_WDT_RST = 2'd2,
        ST_TO_FIX  = 2'd3
    } state_t;

    state_t               state_r;
    logic [TICK_BITS-1:0] base_r;
    logic [TICK_BITS-1:0] base_nxt_s;
    logic [7:0]           pre_r;
    logic [7:0]           pre_nxt_s;
    logic                 base_max_s;
    logic                 pre_hit_s;
    logic                 timeout_s;
    logic                 clear_s;
    logic                 hold_s;

    // Terminal prescaler count for a 1:2^ps ratio.
    function automatic logic [7:0] ps_limit(input logic [2:0] ps_v);
        return (8'd1 << ps_v) - 8'd1;
    endfunction

    assign base_max_s = &base_r;
    assign pre_hit_s  = (pre_r == ps_limit(ps));
    assign timeout_s  = wdt_en & base_max_s & (~psa | pre_hit_s);

    // Next counter values: hold at zero outside RUN/SLEEP, clear on any clearing event.
    always_comb begin
        base_nxt_s = {TICK_BITS{1'b0}};
        pre_nxt_s  = 8'd0;
        clear_s    = 1'b0;
        hold_s     = ~wdt_en;
        case (state_r)
            ST_RUN:   clear_s = sleep | clrwdt | timeout_s;
            ST_SLEEP: clear_s = timeout_s | wake_evt;
            default:  hold_s  = 1'b1;
        endcase
        if (hold_s || clear_s) begin
            base_nxt_s = {TICK_BITS{1'b0}};
            pre_nxt_s  = 8'd0;
        end else begin
            base_nxt_s = base_r + TICK_BITS'(1);
            if (psa && base_max_s) begin
                pre_nxt_s = pre_r + 8'd1;
            end else begin
                pre_nxt_s = pre_r;
            end
        end
    end

    // Watchdog base counter and prescaler registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_r <= {TICK_BITS{1'b0}};
            pre_r  <= 8'd0;
        end else begin
            base_r <= base_nxt_s;
            pre_r  <= pre_nxt_s;
        end
    end

    // Control FSM with registered status writes, halt, reset and wake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            n_to_wr_en <= 1'b0;
            n_to_in    <= 1'b0;
            n_pd_wr_en <= 1'b0;
            n_pd_in    <= 1'b0;
            sleeping   <= 1'b0;
            wdt_reset  <= 1'b0;
            wake       <= 1'b0;
        end else begin
            n_to_wr_en <= 1'b0;
            n_to_in    <= 1'b0;
            n_pd_wr_en <= 1'b0;
            n_pd_in    <= 1'b0;
            wdt_reset  <= 1'b0;
            wake       <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (sleep) begin
                        state_r    <= ST_SLEEP;
                        sleeping   <= 1'b1;
                        n_to_wr_en <= 1'b1;
                        n_to_in    <= 1'b1;
                        n_pd_wr_en <= 1'b1;
                        n_pd_in    <= 1'b0;
                    end else if (clrwdt) begin
                        n_to_wr_en <= 1'b1;
                        n_to_in    <= 1'b1;
                        n_pd_wr_en <= 1'b1;
                        n_pd_in    <= 1'b1;
                    end else if (timeout_s) begin
                        state_r   <= ST_WDT_RST;
                        wdt_reset <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_SLEEP: begin
                    // A watchdog overflow in sleep is a wake-up, not a reset.
                    if (timeout_s) begin
                        state_r    <= ST_RUN;
                        sleeping   <= 1'b0;
                        wake       <= 1'b1;
                        n_to_wr_en <= 1'b1;
                        n_to_in    <= 1'b0;
                    end else if (wake_evt) begin
                        state_r  <= ST_RUN;
                        sleeping <= 1'b0;
                        wake     <= 1'b1;
                    end else begin
                        state_r <= ST_SLEEP;
                    end
                end
                ST_WDT_RST: begin
                    // TO is written after the core reset so it outlives the status reset value.
                    state_r    <= ST_TO_FIX;
                    n_to_wr_en <= 1'b1;
                    n_to_in    <= 1'b0;
                end
                ST_TO_FIX: begin
                    state_r <= ST_RUN;
                end
                default: begin
                    state_r  <= ST_RUN;
                    sleeping <= 1'b0;
                end
            endcase
        end
    end

endmodule
